// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: defaults, FSM
// encoding and the row/column to hex code map.
package keypad_pkg;

    localparam int SCAN_BITS_DEF = 15;
    localparam int DEB_SCANS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    // Indexed by {row, col}, both zero-based
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] key_code_of(
        input logic [1:0] r,
        input logic [1:0] c
    );
        return KEY_MAP[{r, c}];
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs.
// Resets to all-ones, the idle level of pulled-up lines.
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce and an eight-nibble
// hex entry shift register.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_BITS = SCAN_BITS_DEF,
    parameter int DEB_SCANS = DEB_SCANS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:1]  row,
    output logic [4:1]  col,
    input  logic        clr,
    output logic [32:1] data,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    logic [4:1]           w_row_s;
    logic [3:0]           w_low;
    logic [2:0]           w_nz;
    logic [2:0]           w_tot;
    logic [1:0]           w_lrow;
    logic [3:0]           w_code;
    logic                 w_slot_end;
    logic                 w_single;
    logic                 w_none;
    logic                 w_deb_done;

    logic [SCAN_BITS-1:0] r_slot;
    logic [1:0]           r_idx;
    logic [1:0]           r_nlow;
    logic [3:0]           r_code;
    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [3:0]           r_cand;
    logic [32:1]          r_data;
    logic [3:0]           r_key;
    logic                 r_valid;

    sync2 #(.W(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (row),
        .o_q (w_row_s)
    );

    assign w_low      = ~w_row_s;
    assign w_nz       = 3'($countones(w_low));
    assign w_tot      = {1'b0, r_nlow} + w_nz;
    assign w_slot_end = &r_slot;
    assign w_single   = (w_tot == 3'd1);
    assign w_none     = (w_tot == 3'd0);
    assign w_deb_done = (int'(r_cnt) + 1 >= DEB_SCANS);

    always_comb begin
        w_lrow = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_low[i]) w_lrow = 2'(i);
        end
    end

    // The single low bit of a scan was either seen earlier or is here now
    assign w_code = (r_nlow == 2'd0) ? key_code_of(w_lrow, r_idx)
                                     : r_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot  <= '0;
            r_idx   <= 2'd0;
            r_nlow  <= 2'd0;
            r_code  <= 4'h0;
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_cand  <= 4'h0;
            r_data  <= '0;
            r_key   <= 4'h0;
            r_valid <= 1'b0;
        end else begin
            r_slot  <= r_slot + {{(SCAN_BITS-1){1'b0}}, 1'b1};
            r_valid <= 1'b0;
            if (w_slot_end) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx != 2'd3) begin
                    r_nlow <= (w_tot > 3'd1) ? 2'd2 : w_tot[1:0];
                    r_code <= w_code;
                end else begin
                    r_nlow <= 2'd0;
                    unique case (r_state)
                        ST_IDLE: begin
                            if (w_single) begin
                                r_cand <= w_code;
                                if (DEB_SCANS <= 1) begin
                                    r_valid <= 1'b1;
                                    r_key   <= w_code;
                                    r_data  <= {r_data[28:1], w_code};
                                    r_state <= ST_HELD;
                                end else begin
                                    r_cnt   <= 8'd1;
                                    r_state <= ST_DEBOUNCE;
                                end
                            end
                        end
                        ST_DEBOUNCE: begin
                            if (w_single && w_code == r_cand) begin
                                if (w_deb_done) begin
                                    r_valid <= 1'b1;
                                    r_key   <= r_cand;
                                    r_data  <= {r_data[28:1], r_cand};
                                    r_state <= ST_HELD;
                                end else begin
                                    r_cnt <= r_cnt + 8'd1;
                                end
                            end else begin
                                r_cnt   <= 8'd0;
                                r_state <= ST_IDLE;
                            end
                        end
                        ST_HELD: begin
                            if (w_none) begin
                                r_cnt   <= 8'd1;
                                r_state <= ST_RELEASE;
                            end
                        end
                        ST_RELEASE: begin
                            if (!w_none) begin
                                r_state <= ST_HELD;
                            end else if (w_deb_done) begin
                                r_cnt   <= 8'd0;
                                r_state <= ST_IDLE;
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
            // Clear overrides a same-cycle shift
            if (clr) r_data <= '0;
        end
    end

    assign col       = ~(4'b0001 << r_idx);
    assign data      = r_data;
    assign key_code  = r_key;
    assign key_valid = r_valid;

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_BITS, default 15, SHALL set the width of the column-slot counter, giving 2^SCAN_BITS clk cycles per column slot.
REQ-002 Parameter DEB_SCANS, default 4, SHALL set the number of consecutive identical full scans required to accept a press or a release.
REQ-003 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1: reset; one clock domain, synchronous, active-high.
REQ-005 Port row, input, [4:1]: keypad row lines; active-low, pulled up externally, asynchronous.
REQ-006 Port col, output, [4:1]: column strobes; active-low one-hot.
REQ-007 Port clr, input, 1: synchronous clear of the entry register.
REQ-008 Port data, output, [32:1]: hex entry register of eight nibbles, data[4:1] newest.
REQ-009 Port key_code, output, [3:0]: code of the last accepted key.
REQ-010 Port key_valid, output, 1: one-cycle pulse on key acceptance.

Function
REQ-011 row SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Slot counter SHALL increment every cycle and wrap; at all-ones, column index SHALL advance 0->1->2->3->0, with col = active-low one-hot of the index (index 0 -> col=4'b1110).
REQ-013 Synchronized row SHALL be sampled in the all-ones cycle of each slot; the end of the index-3 slot SHALL be the scan end.
REQ-014 Scan result SHALL be NONE (no low bit in any of the 4 samples), SINGLE(code) (exactly one low bit total), or MULTI (more than one); MULTI SHALL be treated as NONE for acceptance and as a key for release.
REQ-015 Code map (row,col -> hex): r1: 1,2,3,A; r2: 4,5,6,B; r3: 7,8,9,C; r4: E,0,F,D.
REQ-016 FSM states IDLE, DEBOUNCE, HELD, RELEASE SHALL be evaluated only at scan end.
REQ-017 IDLE: SINGLE(K) -> DEBOUNCE, cand=K, cnt=1; otherwise stay.
REQ-018 DEBOUNCE: SINGLE(cand) -> cnt+1; reaching DEB_SCANS -> accept and go to HELD; any other result -> IDLE.
REQ-019 Accept: in the cycle after that scan end, key_valid=1 for exactly one cycle, key_code=cand, data={data[28:1],cand}; the oldest nibble is discarded.
REQ-020 HELD: NONE -> RELEASE, cnt=1; otherwise stay; no repeat pulses.
REQ-021 RELEASE: NONE -> cnt+1; reaching DEB_SCANS -> IDLE; any key or MULTI -> HELD.
REQ-022 clr SHALL zero data the next cycle; if clr coincides with accept, clr SHALL win and data SHALL be 0, while key_valid and key_code still update.
REQ-023 DEB_SCANS=1 SHALL accept on the first SINGLE scan, going IDLE->HELD directly.

Reset
REQ-024 rst SHALL set slot counter=0, column index=0 (col=4'b1110), data=0, key_code=0, key_valid=0, FSM=IDLE, cnt=0, cand=0, synchronizer flops=4'b1111.
REQ-025 rst asserted mid-debounce or mid-hold SHALL discard the candidate; a key still held after reset SHALL need a full DEB_SCANS debounce before acceptance.

Structure
REQ-026 The code-map table, FSM state encoding, and DEB_SCANS/SCAN_BITS defaults SHALL reside in a shared package, keypad_pkg.
REQ-027 The row synchronizer SHALL be a separate sub-module, sync2, of width 4.

Verification (SCAN_BITS=2, DEB_SCANS=2; 16 cycles/scan)
REQ-028 After reset, with row=4'b1111 -> col=4'b1110, data=0, key_valid never set over 10 scans.
REQ-029 Key r2c3 held for 6 scans -> one key_valid pulse, key_code=6, data=32'h00000006; after release plus 2 more presses of key 1 -> data=32'h00000611.
REQ-030 Key r1c1 held for exactly 1 scan -> no key_valid; FSM returns to IDLE.
REQ-031 Keys r1c1 and r3c2 held together for 5 scans -> no key_valid.
REQ-032 Enter nine digits 1..9 -> data=32'h23456789; then assert clr -> data=0.
REQ-033 rst pulsed during DEBOUNCE with key 5 still held -> key_valid follows only 2 scans after reset, key_code=5.
